oam_dma: RTL and testbench

- Bus initiator that performs the Game Boy OAM DMA transfer: copies 160 bytes from page XX00–XX9F into OAM FE00–FE9F after a CPU write to register FF46.
- Drives the read side of the memory bus as the requester toward peripherals such as WRAM, ROM and VRAM.
- Drives a dedicated write port into OAM.
- Exposes dma_active so the CPU-side bus logic can block non-HRAM accesses during the transfer.

---
 rtl/oam_dma_pkg.sv | 16 +
 rtl/oam_dma.sv | 100 ++++++++++
 tb/tb_oam_dma.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_pkg.sv
// Shared memory-map constants and helpers for the OAM DMA engine.
// Address decode lives here so the CPU bus logic and the DMA agree on one map.
package oam_dma_pkg;

    localparam int          OAM_LEN      = 160;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] OAM_END      = OAM_BASE + 16'(OAM_LEN - 1);
    localparam logic [7:0]  LAST_IDX     = 8'(OAM_LEN - 1);

    // Pages E0-FF are the echo of WRAM, so fold them back down to C0-DF.
    function automatic logic [7:0] src_page(input logic [7:0] base);
        return (base >= 8'hE0) ? base - 8'h20 : base;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// Game Boy OAM DMA: a write to FF46 copies 160 bytes from page XX00 into FE00-FE9F,
// reading one byte per M-cycle and writing it to OAM on the following M-cycle.
module oam_dma
    import oam_dma_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mcycle_tick,
    input  logic [15:0] reg_addr,
    input  logic        reg_write_en,
    input  logic        reg_read_en,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic [15:0] src_addr,
    output logic        src_read_en,
    input  logic [7:0]  src_rdata,
    output logic [15:0] oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_write_en,
    output logic        dma_active
);

    typedef enum logic [1:0] {IDLE, START, XFER, DRAIN} dma_state_t;

    dma_state_t state, state_nx;
    logic [7:0] base_reg;
    logic [7:0] idx, idx_nx;
    logic [7:0] wr_idx, wr_idx_nx;
    logic       pending, pending_nx;
    logic [7:0] hold, hold_nx;
    logic       trigger;
    logic       active;

    assign trigger = reg_write_en && (reg_addr == DMA_REG_ADDR);
    assign active  = (state == XFER) || (state == DRAIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            base_reg <= 8'hFF;
            idx      <= '0;
            wr_idx   <= '0;
            pending  <= 1'b0;
            hold     <= '0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            wr_idx  <= wr_idx_nx;
            pending <= pending_nx;
            hold    <= hold_nx;
            if (trigger) begin
                base_reg <= reg_wdata;
            end
        end
    end

    // A trigger wins over a coincident tick: the in-flight byte is dropped.
    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        wr_idx_nx  = wr_idx;
        pending_nx = pending;
        hold_nx    = hold;
        if (trigger) begin
            state_nx   = START;
            idx_nx     = '0;
            pending_nx = 1'b0;
        end else if (mcycle_tick) begin
            case (state)
                START: state_nx = XFER;
                XFER: begin
                    hold_nx    = src_rdata;
                    wr_idx_nx  = idx;
                    pending_nx = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_nx = DRAIN;
                    end else begin
                        idx_nx = idx + 8'd1;
                    end
                end
                DRAIN: begin
                    pending_nx = 1'b0;
                    state_nx   = IDLE;
                end
                default: state_nx = state;
            endcase
        end
    end

    // Bus contract: src_rdata answers src_addr combinationally while src_read_en is
    // high; OAM captures oam_addr/oam_wdata on any posedge where oam_write_en is high.
    assign dma_active   = active;
    assign src_read_en  = (state == XFER);
    assign src_addr     = src_read_en ? {src_page(base_reg), idx} : 16'h0000;
    assign oam_write_en = mcycle_tick && pending && active && !trigger;
    assign oam_addr     = (pending && active) ? OAM_BASE + {8'h00, wr_idx} : 16'h0000;
    assign oam_wdata    = (pending && active) ? hold : 8'h00;
    assign reg_rdata    = (reg_read_en && (reg_addr == DMA_REG_ADDR)) ? base_reg : 8'hFF;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: source memory model, OAM capture and an ordered
// queue of expected OAM writes, with one M-cycle tick every 4 clocks.
module tb_oam_dma;

    logic        clk;
    logic        reset;
    logic        mcycle_tick;
    logic [15:0] reg_addr;
    logic        reg_write_en;
    logic        reg_read_en;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic [15:0] src_addr;
    logic        src_read_en;
    logic [7:0]  src_rdata;
    logic [15:0] oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_write_en;
    logic        dma_active;

    logic [7:0]  src_mem [0:65535];
    logic [7:0]  oam_mem [0:255];
    logic [23:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int tick_num = 0;
    int wr_count = 0;
    int first_act, last_act, first_wr, last_wr;

    oam_dma dut (
        .clk(clk), .reset(reset), .mcycle_tick(mcycle_tick),
        .reg_addr(reg_addr), .reg_write_en(reg_write_en), .reg_read_en(reg_read_en),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .src_addr(src_addr), .src_read_en(src_read_en), .src_rdata(src_rdata),
        .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_write_en(oam_write_en),
        .dma_active(dma_active)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign src_rdata = src_read_en ? src_mem[src_addr] : 8'h00;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        wr_count = 0;
        first_act = -1; last_act = -1;
        first_wr = -1; last_wr = -1;
    endtask

    // Sampled mid-cycle while mcycle_tick is high, i.e. just before the edge that commits it.
    task automatic capture(input bit trig);
        logic [23:0] e;
        if (dma_active) begin
            if (first_act < 0) first_act = tick_num;
            last_act = tick_num;
        end
        if (trig) begin
            check("no_write_on_trigger", 24'(oam_write_en), 24'd0);
        end else if (oam_write_en) begin
            wr_count++;
            if (first_wr < 0) first_wr = tick_num;
            last_wr = tick_num;
            oam_mem[oam_addr[7:0]] = oam_wdata;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {oam_addr, oam_wdata}, 24'hFFFFFF);
            end else begin
                e = exp_q.pop_front();
                check("oam_write", {oam_addr, oam_wdata}, e);
            end
        end
    endtask

    // driver: one M-cycle = 4 clocks, tick high for the first
    task automatic do_tick(input bit trig, input logic [7:0] data);
        @(negedge clk);
        mcycle_tick = 1'b1;
        if (trig) begin
            reg_addr     = 16'hFF46;
            reg_wdata    = data;
            reg_write_en = 1'b1;
            tick_num     = 0;
        end
        #1;
        capture(trig);
        @(negedge clk);
        mcycle_tick  = 1'b0;
        reg_write_en = 1'b0;
        tick_num++;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_ticks(input int n);
        for (int k = 0; k < n; k++) do_tick(1'b0, 8'h00);
    endtask

    task automatic push_page(input logic [15:0] base, input int count);
        for (int i = 0; i < count; i++)
            exp_q.push_back({16'hFE00 + 16'(i), src_mem[base + 16'(i)]});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_active"}, 24'(dma_active), 24'd0);
        check({tag, "_src_en"}, 24'(src_read_en), 24'd0);
        check({tag, "_src_addr"}, 24'(src_addr), 24'd0);
        check({tag, "_oam_we"}, 24'(oam_write_en), 24'd0);
        check({tag, "_oam_addr"}, 24'(oam_addr), 24'd0);
        check({tag, "_oam_wdata"}, 24'(oam_wdata), 24'd0);
        check({tag, "_rdata"}, 24'(reg_rdata), 24'hFF);
    endtask

    initial begin
        logic [15:0] fz_src, fz_oam;
        logic [7:0]  fz_data;
        int          quiet;

        reset = 1'b1; mcycle_tick = 1'b0;
        reg_addr = 16'h0000; reg_write_en = 1'b0; reg_read_en = 1'b0; reg_wdata = 8'h00;
        for (int a = 0; a < 65536; a++) src_mem[a] = 8'h00;
        for (int i = 0; i < 160; i++) begin
            src_mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
            src_mem[16'hC100 + 16'(i)] = 8'(i) + 8'h03;
            src_mem[16'hD000 + 16'(i)] = 8'(i) ^ 8'hA5;
        end
        for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;
        clear_stats();

        // reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // register readback (no tick, so the engine sits in START)
        reg_addr = 16'hFF46; reg_wdata = 8'h12; reg_write_en = 1'b1;
        @(negedge clk);
        reg_write_en = 1'b0; reg_read_en = 1'b1;
        #1 check("rd_ff46", 24'(reg_rdata), 24'h12);
        reg_addr = 16'hFF47;
        #1 check("rd_ff47", 24'(reg_rdata), 24'hFF);
        reg_addr = 16'hFF46; reg_read_en = 1'b0;
        #1 check("rd_no_strobe", 24'(reg_rdata), 24'hFF);
        check("start_inactive", 24'(dma_active), 24'd0);

        // basic copy from C000, with a 20-clock tick gap after tick 40
        clear_stats();
        push_page(16'hC000, 160);
        do_tick(1'b1, 8'hC0);
        run_ticks(40);
        fz_src = src_addr; fz_oam = oam_addr; fz_data = oam_wdata;
        check("gap_src_addr", 24'(src_addr), 24'hC027);
        check("gap_oam_addr", 24'(oam_addr), 24'hFE26);
        check("gap_oam_wdata", 24'(oam_wdata), 24'h7C);
        quiet = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (oam_write_en) quiet++;
        end
        check("gap_no_write", 24'(quiet), 24'd0);
        check("gap_src_frozen", 24'(src_addr), 24'(fz_src));
        check("gap_oam_frozen", {oam_addr, oam_wdata}, {fz_oam, fz_data});
        check("gap_active", 24'(dma_active), 24'd1);
        run_ticks(124);
        check("copy_writes", 24'(wr_count), 24'd160);
        check("copy_queue_empty", 24'(exp_q.size()), 24'd0);
        check("copy_first_active", 24'(first_act), 24'd2);
        check("copy_last_active", 24'(last_act), 24'd162);
        check("copy_first_write", 24'(first_wr), 24'd3);
        check("copy_last_write", 24'(last_wr), 24'd162);
        check("copy_oam0", 24'(oam_mem[0]), 24'h5A);
        check("copy_oam159", 24'(oam_mem[159]), 24'hC5);
        check("copy_idle", 24'(dma_active), 24'd0);

        // echo mapping: page E1 reads WRAM C1
        clear_stats();
        push_page(16'hC100, 160);
        do_tick(1'b1, 8'hE1);
        run_ticks(1);
        check("echo_src_en", 24'(src_read_en), 24'd1);
        check("echo_src_addr", 24'(src_addr), 24'hC100);
        run_ticks(162);
        check("echo_writes", 24'(wr_count), 24'd160);
        check("echo_queue_empty", 24'(exp_q.size()), 24'd0);
        check("echo_oam5", 24'(oam_mem[5]), 24'h08);

        // restart mid-transfer after 48 bytes have been written
        clear_stats();
        push_page(16'hC000, 48);
        push_page(16'hD000, 160);
        do_tick(1'b1, 8'hC0);
        run_ticks(50);
        check("restart_pre_writes", 24'(wr_count), 24'd48);
        do_tick(1'b1, 8'hD0);
        run_ticks(2);
        check("restart_idx0", 24'(src_addr), 24'hD001);
        run_ticks(162);
        check("restart_writes", 24'(wr_count), 24'd208);
        check("restart_queue_empty", 24'(exp_q.size()), 24'd0);
        check("restart_oam0", 24'(oam_mem[0]), 24'hA5);
        check("restart_oam159", 24'(oam_mem[159]), 24'h3A);

        // reset at tick 80: bytes 0..76 written, the rest untouched
        clear_stats();
        for (int i = 0; i < 160; i++) oam_mem[i] = 8'h33;
        push_page(16'hC000, 160);
        do_tick(1'b1, 8'hC0);
        run_ticks(79);
        @(negedge clk);
        mcycle_tick = 1'b1; reset = 1'b1;
        reg_addr = 16'hFF46; reg_read_en = 1'b1;
        #1 check_idle_outputs("abort");
        @(negedge clk);
        mcycle_tick = 1'b0; reg_read_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_ticks(5);
        check("abort_writes", 24'(wr_count), 24'd77);
        check("abort_queue_left", 24'(exp_q.size()), 24'd83);
        check("abort_oam76", 24'(oam_mem[76]), 24'h16);
        check("abort_oam77", 24'(oam_mem[77]), 24'h33);
        check("abort_oam159", 24'(oam_mem[159]), 24'h33);
        check_idle_outputs("abort_after");
        exp_q.delete();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
